// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the DataMemory side of the arbiter.
//   slave  : arbiter view. It takes requests and mem_dataOut, and drives
//            ready, rdata and the memory strobes, address and data.
//   master : requester/memory view, used by whatever sits around the arbiter.
//   Signals:
//     pN_rd, pN_wr      level requests, held until pN_ready
//     pN_addr, pN_wdata request address / write data
//     pN_rdata, pN_ready registered read data and one-cycle completion pulse
//     mem_readSig, mem_writeSig, mem_address, mem_dataIn  DataMemory drive
//     mem_dataOut       DataMemory read data
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_rd, p0_wr, p0_ready;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_rd, p1_wr, p1_ready;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic              mem_readSig, mem_writeSig;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_dataIn, mem_dataOut;

  modport slave (
    input  p0_rd, p0_wr, p0_addr, p0_wdata,
    output p0_rdata, p0_ready,
    input  p1_rd, p1_wr, p1_addr, p1_wdata,
    output p1_rdata, p1_ready,
    output mem_readSig, mem_writeSig, mem_address, mem_dataIn,
    input  mem_dataOut
  );

  modport master (
    output p0_rd, p0_wr, p0_addr, p0_wdata,
    input  p0_rdata, p0_ready,
    output p1_rd, p1_wr, p1_addr, p1_wdata,
    input  p1_rdata, p1_ready,
    input  mem_readSig, mem_writeSig, mem_address, mem_dataIn,
    output mem_dataOut
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port DataMemory between port 0 (pipeline MEM stage)
//   and port 1 (debug/loader). Each access holds the memory strobes for
//   WAIT_CYCLES cycles. After that, the granted port receives a one-cycle
//   ready pulse, and read data is captured into its rdata register.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-low reset
//     bus  dmem_arbiter_if.slave (requester ports + DataMemory side)
//   Build option:
//     DMEM_ARB_FIXED_PRIO_EN  port 0 always wins ties (default: round-robin)
//
//   state  | meaning
//   IDLE   | pick a requester, latch op/addr/wdata
//   ACCESS | strobe held, wait counter running down
//   DONE   | ready pulse to granted port, requests ignored
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              port_q;
  logic              p0_req, p1_req, pick1, grant, finish;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign p0_req = bus.p0_rd | bus.p0_wr;
  assign p1_req = bus.p1_rd | bus.p1_wr;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick1 = ~p0_req;
`else
  // last_grant = 1 means port 1 was served last, so port 0 wins the next tie.
  logic last_grant;
  assign pick1 = p1_req & (~p0_req | ~last_grant);
`endif

  // rd and wr together is treated as a write.
  always_comb begin
    sel_wr    = pick1 ? bus.p1_wr    : bus.p0_wr;
    sel_addr  = pick1 ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = pick1 ? bus.p1_wdata : bus.p0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (p0_req | p1_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The strobes, address and data are registered, so they double as the
  // latched transaction. The async reset therefore drops the strobes at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt              <= 4'd0;
      port_q           <= 1'b0;
      bus.mem_readSig  <= 1'b0;
      bus.mem_writeSig <= 1'b0;
      bus.mem_address  <= '0;
      bus.mem_dataIn   <= '0;
      bus.p0_rdata     <= '0;
      bus.p1_rdata     <= '0;
      bus.p0_ready     <= 1'b0;
      bus.p1_ready     <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant       <= 1'b1;
`endif
    end else begin
      bus.p0_ready <= 1'b0;
      bus.p1_ready <= 1'b0;
      if (grant) begin
        port_q           <= pick1;
        bus.mem_readSig  <= ~sel_wr;
        bus.mem_writeSig <= sel_wr;
        bus.mem_address  <= sel_addr;
        bus.mem_dataIn   <= sel_wdata;
        cnt              <= 4'(WAIT_CYCLES - 1);
      end else if (finish) begin
        bus.mem_readSig  <= 1'b0;
        bus.mem_writeSig <= 1'b0;
        if (port_q) bus.p1_ready <= 1'b1;
        else        bus.p0_ready <= 1'b1;
        if (bus.mem_readSig) begin
          if (port_q) bus.p1_rdata <= bus.mem_dataOut;
          else        bus.p0_rdata <= bus.mem_dataOut;
        end
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant <= port_q;
`endif
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter (WAIT_CYCLES=2) with a small behavioural
//   DataMemory. Inputs change and outputs are sampled 1 time unit after a
//   rising edge.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   asserts = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.WAIT_CYCLES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [0:1023];
  assign bus.mem_dataOut = mem[bus.mem_address[9:0]];
  always @(posedge clk) if (bus.mem_writeSig) mem[bus.mem_address[9:0]] <= bus.mem_dataIn;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.p0_rd = 0; bus.p0_wr = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_rd = 0; bus.p1_wr = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic test_reset;
    logic [135:0] outs;
    rst = 0;
    bus.p0_rd = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      outs = {bus.mem_readSig, bus.mem_writeSig, bus.mem_address[31:0], bus.mem_dataIn[31:0],
              bus.p0_ready, bus.p1_ready, bus.p0_rdata[31:0], bus.p1_rdata[31:0]};
      asserts++;
      if (outs !== '0) begin failures++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs); end
    end
    rst = 1;
    step;
    asserts++;
    if (bus.mem_readSig !== 1'b1) begin failures++; $display("FAIL reset_grant_strobe: got %b expected 1", bus.mem_readSig); end
    step;
    asserts++;
    if ({bus.mem_readSig, bus.p0_ready} !== 2'b10) begin failures++; $display("FAIL reset_access2: got %b expected 10", {bus.mem_readSig, bus.p0_ready}); end
    step;
    asserts++;
    if ({bus.mem_readSig, bus.p0_ready} !== 2'b01) begin failures++; $display("FAIL reset_ready: got %b expected 01", {bus.mem_readSig, bus.p0_ready}); end
    bus.p0_rd = 0;
    step;
    asserts++;
    if (bus.p0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_pulse: got %b expected 0", bus.p0_ready); end
  endtask

  task automatic test_write_read;
    bus.p0_wr = 1; bus.p0_addr = 32'h400; bus.p0_wdata = 32'h5555_5555;
    for (int i = 0; i < 2; i++) begin
      step;
      asserts++;
      if ({bus.mem_writeSig, bus.mem_readSig, bus.mem_address, bus.mem_dataIn, bus.p0_ready} !== {2'b10, 32'h400, 32'h5555_5555, 1'b0}) begin
        failures++; $display("FAIL wr_access cycle %0d: got w%b r%b a=%h d=%h rdy=%b expected w1 r0 a=400 d=55555555 rdy=0",
                             i, bus.mem_writeSig, bus.mem_readSig, bus.mem_address, bus.mem_dataIn, bus.p0_ready);
      end
    end
    step;
    asserts++;
    if ({bus.mem_writeSig, bus.p0_ready} !== 2'b01) begin failures++; $display("FAIL wr_ready: got %b expected 01", {bus.mem_writeSig, bus.p0_ready}); end
    bus.p0_wr = 0;
    step;
    bus.p0_rd = 1;
    step;
    step;
    step;
    asserts++;
    if ({bus.p0_ready, bus.p0_rdata} !== {1'b1, 32'h5555_5555}) begin
      failures++; $display("FAIL rd_data: got rdy=%b data=%h expected rdy=1 data=55555555", bus.p0_ready, bus.p0_rdata);
    end
    bus.p0_rd = 0;
    step;
  endtask

  task automatic test_simultaneous;
    rst = 0;
    step;
    rst = 1;
    bus.p0_wr = 1; bus.p0_addr = 32'h406; bus.p0_wdata = 32'hAAAA_AAAA;
    bus.p1_rd = 1; bus.p1_addr = 32'h400;
    step;
    asserts++;
    if ({bus.mem_writeSig, bus.mem_readSig, bus.mem_address} !== {2'b10, 32'h406}) begin
      failures++; $display("FAIL sim_first_grant: got w%b r%b a=%h expected w1 r0 a=406", bus.mem_writeSig, bus.mem_readSig, bus.mem_address);
    end
    step;
    step;
    asserts++;
    if ({bus.p0_ready, bus.p1_ready, bus.p0_rdata} !== {2'b10, 32'h0}) begin
      failures++; $display("FAIL sim_p0_done: got r0=%b r1=%b p0_rdata=%h expected 1 0 00000000", bus.p0_ready, bus.p1_ready, bus.p0_rdata);
    end
    bus.p0_wr = 0;
    step;
    asserts++;
    if ({bus.mem_writeSig, bus.mem_readSig} !== 2'b00) begin failures++; $display("FAIL sim_gap: got %b expected 00", {bus.mem_writeSig, bus.mem_readSig}); end
    step;
    asserts++;
    if ({bus.mem_writeSig, bus.mem_readSig, bus.mem_address} !== {2'b01, 32'h400}) begin
      failures++; $display("FAIL sim_second_grant: got w%b r%b a=%h expected w0 r1 a=400", bus.mem_writeSig, bus.mem_readSig, bus.mem_address);
    end
    step;
    step;
    asserts++;
    if ({bus.p1_ready, bus.p1_rdata, bus.p0_ready} !== {1'b1, 32'h5555_5555, 1'b0}) begin
      failures++; $display("FAIL sim_p1_data: got rdy=%b data=%h p0rdy=%b expected 1 55555555 0", bus.p1_ready, bus.p1_rdata, bus.p0_ready);
    end
    bus.p1_rd = 0;
    step;
    asserts++;
    if (mem[10'h006] !== 32'hAAAA_AAAA) begin failures++; $display("FAIL sim_mem_write: got %h expected aaaaaaaa", mem[10'h006]); end
  endtask

  task automatic test_round_robin;
    int got;
    int exp_port;
    logic [31:0] data;
    bus.p0_rd = 1; bus.p0_addr = 32'h400;
    bus.p1_rd = 1; bus.p1_addr = 32'h406;
    for (int n = 0; n < 8; n++) begin
      got = -1;
      data = '0;
      for (int c = 0; c < 8 && got < 0; c++) begin
        step;
        if (bus.p0_ready) begin got = 0; data = bus.p0_rdata; end
        else if (bus.p1_ready) begin got = 1; data = bus.p1_rdata; end
      end
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = n % 2;
`endif
      asserts++;
      if (got != exp_port) begin failures++; $display("FAIL rr_grant %0d: got port %0d expected port %0d", n, got, exp_port); end
      asserts++;
      if (got >= 0 && data !== (exp_port == 0 ? 32'h5555_5555 : 32'hAAAA_AAAA)) begin
        failures++; $display("FAIL rr_data %0d: got %h for port %0d", n, data, exp_port);
      end
    end
    bus.p0_rd = 0; bus.p1_rd = 0;
    step;
    step;
  endtask

  task automatic test_reset_mid_access;
    bus.p0_wr = 1; bus.p0_addr = 32'h409; bus.p0_wdata = 32'hFFFF_0000;
    step;
    asserts++;
    if (bus.mem_writeSig !== 1'b1) begin failures++; $display("FAIL mid_first_access: got %b expected 1", bus.mem_writeSig); end
    step;
    #1 rst = 0;
    #1;
    asserts++;
    if ({bus.mem_writeSig, bus.mem_readSig, bus.mem_address} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL mid_strobe_drop: got w%b r%b a=%h expected w0 r0 a=0", bus.mem_writeSig, bus.mem_readSig, bus.mem_address);
    end
    bus.p0_wr = 0;
    step;
    step;
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      step;
      asserts++;
      if ({bus.p0_ready, bus.p1_ready, bus.mem_writeSig, bus.mem_readSig, bus.p0_rdata, bus.p1_rdata} !== '0) begin
        failures++; $display("FAIL mid_after_release cycle %0d: got rdy=%b%b w%b r%b d0=%h d1=%h expected all 0",
                             i, bus.p0_ready, bus.p1_ready, bus.mem_writeSig, bus.mem_readSig, bus.p0_rdata, bus.p1_rdata);
      end
    end
  endtask

  task automatic test_both_flags;
    bus.p1_rd = 1; bus.p1_addr = 32'h400;
    step;
    step;
    step;
    asserts++;
    if ({bus.p1_ready, bus.p1_rdata} !== {1'b1, 32'h5555_5555}) begin
      failures++; $display("FAIL both_pre_read: got rdy=%b data=%h expected 1 55555555", bus.p1_ready, bus.p1_rdata);
    end
    bus.p1_rd = 0;
    step;
    bus.p1_rd = 1; bus.p1_wr = 1; bus.p1_addr = 32'h40A; bus.p1_wdata = 32'h1234_5678;
    step;
    asserts++;
    if ({bus.mem_writeSig, bus.mem_readSig} !== 2'b10) begin failures++; $display("FAIL both_strobes: got w%b r%b expected w1 r0", bus.mem_writeSig, bus.mem_readSig); end
    step;
    step;
    asserts++;
    if ({bus.p1_ready, bus.p1_rdata} !== {1'b1, 32'h5555_5555}) begin
      failures++; $display("FAIL both_rdata_kept: got rdy=%b data=%h expected 1 55555555", bus.p1_ready, bus.p1_rdata);
    end
    bus.p1_rd = 0; bus.p1_wr = 0;
    step;
    asserts++;
    if (mem[10'h00A] !== 32'h1234_5678) begin failures++; $display("FAIL both_mem_write: got %h expected 12345678", mem[10'h00A]); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_write_read();
    test_simultaneous();
    test_round_robin();
    test_reset_mid_access();
    test_both_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
